// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the saturating update rule and the table read-response bundle.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic        hit;
        logic        cnt_msb;
        logic [31:0] target;
    } bp_rd_t;

    function automatic logic [1:0] sat2_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'b01;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: valid/tag/target/counter arrays with one
// combinational read port and one clocked read-modify-write training port.
import bp_pkg::*;

module bp_table #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output bp_rd_t           rd_rsp,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [31:0]      wr_target
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][1:0]       cnt_q,   cnt_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q,   tag_d;
    logic [ENTRIES-1:0][31:0]      target_q, target_d;
    logic                          wr_hit;

    // Read port sees only registered state, so a same-cycle write is not bypassed.
    always_comb begin
        rd_rsp.hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_rsp.cnt_msb = cnt_q[rd_idx][1];
        rd_rsp.target  = target_q[rd_idx];
    end

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            if (wr_hit) begin
                cnt_d[wr_idx] = sat2_update(cnt_q[wr_idx], wr_taken);
                if (wr_taken) begin
                    target_d[wr_idx] = wr_target;
                end
            end else if (wr_taken) begin
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = wr_target;
                cnt_d[wr_idx]    = CNT_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= {ENTRIES{CNT_WNT}};
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag/target carry no reset; a cleared valid bit hides them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller: IF-stage lookup, EX-stage resolve/redirect,
// BTB training and resolved/mispredicted branch counters.
import bp_pkg::*;

module branch_pred_ctrl #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        pred_taken_if,
    output logic [31:0] pred_target_if,
    input  logic        br_valid_ex,
    input  logic [31:0] br_pc_ex,
    input  logic        br_taken_ex,
    input  logic [31:0] br_target_ex,
    input  logic        pred_taken_ex,
    input  logic [31:0] pred_target_ex,
    input  logic        bubble_ex,
    output logic        redirect_ex,
    output logic [31:0] redirect_pc_ex,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int          TAG_LSB = IDX_W + 2;
    localparam int          PC_TOP  = TAG_LSB + TAG_W;
    localparam logic [31:0] PC_HI   = (PC_TOP >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'h1 << PC_TOP) - 32'h1);
    localparam logic [31:0] PC_USED = PC_HI & ~32'h3;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    bp_rd_t           if_rsp;
    logic             active, mispredict;
    logic [31:0]      br_cnt_q, br_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;
    logic             unused_pc_bits;

    assign if_idx = pc_if[IDX_W+1:2];
    assign if_tag = pc_if[PC_TOP-1:TAG_LSB];
    assign ex_idx = br_pc_ex[IDX_W+1:2];
    assign ex_tag = br_pc_ex[PC_TOP-1:TAG_LSB];

    // Byte-offset bits and any PC bits above the tag play no part in lookup.
    assign unused_pc_bits = ^{pc_if & ~PC_USED, br_pc_ex & ~PC_USED};

    bp_table #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_idx),
        .rd_tag    (if_tag),
        .rd_rsp    (if_rsp),
        .wr_en     (active),
        .wr_idx    (ex_idx),
        .wr_tag    (ex_tag),
        .wr_taken  (br_taken_ex),
        .wr_target (br_target_ex)
    );

    always_comb begin
        pred_taken_if  = if_rsp.hit && if_rsp.cnt_msb;
        pred_target_if = pred_taken_if ? if_rsp.target : 32'h0;
    end

    always_comb begin
        active         = br_valid_ex && !bubble_ex;
        mispredict     = (pred_taken_ex != br_taken_ex) ||
                         (pred_taken_ex && br_taken_ex && (pred_target_ex != br_target_ex));
        redirect_ex    = active && mispredict;
        redirect_pc_ex = br_taken_ex ? br_target_ex : br_pc_ex + 32'd4;
    end

    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (active) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (mispredict) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: directed scenarios then random
// traffic, checked against a behavioural BTB model.
module tb_branch_pred_ctrl;

    localparam int IDX_W = 6;
    localparam int TAG_W = 24;
    localparam int ENT   = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        br_valid_ex;
    logic [31:0] br_pc_ex;
    logic        br_taken_ex;
    logic [31:0] br_target_ex;
    logic        pred_taken_ex;
    logic [31:0] pred_target_ex;
    logic        bubble_ex;
    logic        redirect_ex;
    logic [31:0] redirect_pc_ex;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    branch_pred_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
        .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .br_valid_ex(br_valid_ex), .br_pc_ex(br_pc_ex), .br_taken_ex(br_taken_ex),
        .br_target_ex(br_target_ex), .pred_taken_ex(pred_taken_ex),
        .pred_target_ex(pred_target_ex), .bubble_ex(bubble_ex),
        .redirect_ex(redirect_ex), .redirect_pc_ex(redirect_pc_ex),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Behavioural BTB: entry fields per index, counter as a plain integer 0..3.
    bit          m_val[ENT];
    int          m_cnt[ENT];
    logic [31:0] m_tag[ENT];
    logic [31:0] m_tgt[ENT];
    logic [31:0] m_br, m_mis;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        int i = idx_of(pc);
        return m_val[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : 32'h0;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // One cycle: drive at negedge, record expected pre-edge outputs, advance model.
    task automatic cyc(input bit rst, input logic [31:0] pci, input bit bv,
                       input logic [31:0] bpc, input bit bt, input logic [31:0] btgt,
                       input bit pte, input logic [31:0] ptgte, input bit bub,
                       input bit chk);
        exp_t e;
        bit   act, mis, hit;
        int   i;
        @(negedge clk);
        rst_n = ~rst; pc_if = pci; br_valid_ex = bv; br_pc_ex = bpc; br_taken_ex = bt;
        br_target_ex = btgt; pred_taken_ex = pte; pred_target_ex = ptgte; bubble_ex = bub;
        act    = bv && !bub;
        mis    = (pte != bt) || (pte && bt && (ptgte != btgt));
        e.pt   = m_pred(pci);
        e.ptgt = m_target(pci);
        e.rd   = act && mis;
        e.rpc  = bt ? btgt : bpc + 32'd4;
        e.bc   = m_br;
        e.mc   = m_mis;
        if (chk) exp_q.push_back(e);
        if (rst) begin
            for (int k = 0; k < ENT; k++) begin m_val[k] = 0; m_cnt[k] = 1; end
            m_br = 0; m_mis = 0;
        end else if (act) begin
            i   = idx_of(bpc);
            hit = m_val[i] && (m_tag[i] == tag_of(bpc));
            if (hit) begin
                m_cnt[i] = bt ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                              : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                if (bt) m_tgt[i] = btgt;
            end else if (bt) begin
                m_val[i] = 1; m_tag[i] = tag_of(bpc); m_tgt[i] = btgt; m_cnt[i] = 2;
            end
            m_br  = m_br + 1;
            m_mis = m_mis + (mis ? 1 : 0);
        end
    endtask

    task automatic idle(input logic [31:0] pci);
        cyc(0, pci, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Branch resolved with the prediction the pipeline would have carried down.
    task automatic resolve(input logic [31:0] pci, input logic [31:0] bpc,
                           input bit bt, input logic [31:0] btgt);
        cyc(0, pci, 1, bpc, bt, btgt, m_pred(bpc), m_target(bpc), 0, 1);
    endtask

    // Monitor: compares whatever expectations are pending, away from the edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred_taken_if", {31'h0, pred_taken_if}, {31'h0, e.pt});
                check("pred_target_if", pred_target_if, e.ptgt);
                check("redirect_ex", {31'h0, redirect_ex}, {31'h0, e.rd});
                if (e.rd) check("redirect_pc_ex", redirect_pc_ex, e.rpc);
                check("br_cnt", br_cnt, e.bc);
                check("mispred_cnt", mispred_cnt, e.mc);
            end
        end
    end

    initial begin
        logic [31:0] pc, tg;
        bit          t, pte;
        m_br = 0; m_mis = 0;
        cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 0, 1);
        // Cold lookup, then first taken branch allocates and redirects.
        idle(32'h100);
        cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0, 0, 1);
        idle(32'h100);
        // Not-taken training down to saturation, then one taken step back up.
        for (int k = 0; k < 7; k++) resolve(32'h100, 32'h100, 0, 32'h0);
        idle(32'h100);
        resolve(32'h100, 32'h100, 1, 32'h200);
        idle(32'h100);
        resolve(32'h100, 32'h100, 1, 32'h200);
        idle(32'h100);
        // Alias at the same index with a different tag replaces the entry.
        resolve(32'h100, 32'h100 + (32'h1 << (IDX_W + 2)), 1, 32'h400);
        idle(32'h100);
        idle(32'h100 + (32'h1 << (IDX_W + 2)));
        // Stalled EX with a mispredict: nothing trains, nothing redirects.
        cyc(0, 32'h100, 1, 32'h100, 1, 32'h500, 0, 32'h0, 1, 1);
        idle(32'h100);
        // Same-cycle lookup of the index being retrained sees the old target.
        resolve(32'h140, 32'h140, 1, 32'h600);
        resolve(32'h140, 32'h140, 1, 32'h700);
        idle(32'h140);
        // Reset together with a taken update: the allocation is dropped.
        cyc(1, 32'h180, 1, 32'h180, 1, 32'h800, 0, 32'h0, 0, 1);
        idle(32'h180);
        idle(32'h140);
        // Random traffic over a few aliasing PCs and targets.
        for (int n = 0; n < 2000; n++) begin
            pc  = 32'h1000 + (32'($urandom_range(0, 3)) << 2) + (32'($urandom_range(0, 1)) << 8);
            tg  = 32'h4000 + (32'($urandom_range(0, 3)) << 4);
            t   = ($urandom_range(0, 99) < 60);
            pte = ($urandom_range(0, 9) == 0) ? bit'($urandom_range(0, 1)) : m_pred(pc);
            cyc(($urandom_range(0, 199) == 0), (($urandom_range(0, 1) == 1) ? pc : 32'h1000 + (32'($urandom_range(0, 7)) << 2)),
                ($urandom_range(0, 9) < 7), pc, t, tg, pte,
                (($urandom_range(0, 3) == 0) ? tg : m_target(pc)),
                ($urandom_range(0, 4) == 0), 1);
        end
        @(negedge clk);
        #4;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
